bus_arb_4x4: RTL and testbench
==============================

BUS_ARB_4X4 -- requirements
Module: bus_arb_4x4

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation; legal range 1..15.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; held high while the bus is wanted.
- in0, in1, in2, in3  input  4 each  requester data words.
- gnt  output  4  one-hot grant, registered; 0000 when idle.
- sel2  output  2  binary index of the current owner; drives the mux select.
- out  output  4  registered bus data.
- out_vld  output  1  out holds valid owner data.
- busy  output  1  high in GRANT state.

Function
REQ-003 The FSM SHALL have two states: IDLE and GRANT.
REQ-004 IDLE, req != 0 SHALL grant the winner: GRANT, gnt one-hot, sel2 = index, hold_cnt = 0.
- Winner = first requester at or after ptr, in order ptr, ptr+1, ... mod 4.
REQ-005 IDLE, req == 0 SHALL remain in IDLE with gnt = 0000; sel2 keeps its last value.
REQ-006 GRANT SHALL increment hold_cnt (4 bits) every cycle the owner keeps its grant.
REQ-007 GRANT, owner's req low, others requesting: next edge SHALL grant the round-robin winner directly, with no idle cycle.
REQ-008 GRANT, owner's req low, no other requests: next edge SHALL go to IDLE with gnt = 0000.
REQ-009 GRANT, hold_cnt == MAX_HOLD-1, another requester pending: next edge SHALL rotate to the round-robin winner, excluding the owner.
REQ-010 GRANT, hold_cnt == MAX_HOLD-1, no other requester pending: owner SHALL keep the grant and hold_cnt SHALL return to 0.
REQ-011 On every new grant, ptr SHALL become (winner index + 1) mod 4.
REQ-012 gnt SHALL always be one-hot or zero, and SHALL equal 1 << sel2 whenever busy = 1.
REQ-013 Data path:
- out SHALL equal in[sel2] registered one cycle, i.e. input sampled at cycle n appears at n+1.
- out_vld SHALL be busy delayed one cycle.
- When out_vld = 0, out SHALL be 0000.
REQ-014 req changes on a non-owner line SHALL NOT affect the current grant except through REQ-009.
REQ-015 MAX_HOLD = 1 SHALL rotate every cycle while two or more requesters are active.

Reset
REQ-016 rst high at an edge SHALL force the following values, overriding all other events:
- state IDLE, gnt 0000, sel2 00, ptr 0, hold_cnt 0, out 0000, out_vld 0, busy 0.
REQ-017 Reset mid-grant SHALL drop gnt on the next edge, and out_vld SHALL be 0 from that edge on.
REQ-018 The first request after reset SHALL resolve with priority order 0, 1, 2, 3.

Structure
REQ-019 Package arb_pkg SHALL hold:
- N_REQ = 4, DW = 4
- the state enum {IDLE, GRANT}
- the hold_cnt width
REQ-020 The data path SHALL reuse the existing MUX4x1_4bit as the single sub-module, with sel2 driving its select; the output register is in bus_arb_4x4.
REQ-021 The design SHALL have no latches, and all outputs SHALL be registered except those sourced directly from registered state.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single requester: req = 0100, in2 = 1010. Expect gnt = 0100 and sel2 = 10 one cycle later, then out = 1010 with out_vld = 1 one cycle after that.
- All requesting: req = 1111, MAX_HOLD = 4. Expect grant order 0, 1, 2, 3, 0, each held exactly 4 cycles, with no gap cycles.
- Early release: owner 1 drops req while req3 is high. Expect gnt = 1000 on the next edge and busy never drops.
- Sole owner at MAX_HOLD: req = 0001 for 12 cycles. Expect gnt to stay 0001 with no release; hold_cnt wraps to 0 every 4 cycles.
- Reset mid-grant: rst pulsed while gnt = 0010. Expect gnt = 0000, out_vld = 0, ptr = 0 next edge; then req = 1010 grants 1 first.
- Idle return: all req dropped. Expect gnt = 0000 and busy = 0 next edge, out_vld = 0 one edge later, out = 0000.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, widths and round-robin pick helper for bus_arb_4x4
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int DW     = 4;
    localparam int SEL_W  = 2;
    localparam int HOLD_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Returns {found, index}: first set bit of mask scanning ptr, ptr+1, ... mod 4.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [SEL_W-1:0] ptr);
        logic             found;
        logic [SEL_W-1:0] win;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && mask[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        return {found, win};
    endfunction

endpackage

// File: rtl/MUX4x1_4bit.sv
// rtl/MUX4x1_4bit.sv - 4-to-1 multiplexer of 4-bit words
// Ports: d0..d3 data inputs, sel binary select, y selected word.
module MUX4x1_4bit (
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/bus_arb_4x4.sv
// rtl/bus_arb_4x4.sv - 4-requester round-robin bus arbiter with hold limit and registered data mux
// Ports: clk, rst (sync active-high); req[3:0] requests; in0..in3 requester data;
//        gnt one-hot grant; sel2 owner index; out registered bus data; out_vld data valid;
//        busy high while in GRANT.
module bus_arb_4x4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [DW-1:0]        in0,
    input  logic [DW-1:0]        in1,
    input  logic [DW-1:0]        in2,
    input  logic [DW-1:0]        in3,
    output logic [N_REQ-1:0]     gnt,
    output logic [SEL_W-1:0]     sel2,
    output logic [DW-1:0]        out,
    output logic                 out_vld,
    output logic                 busy
);

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_d;
    logic [SEL_W-1:0]    sel_d;
    logic [SEL_W-1:0]    ptr, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [N_REQ-1:0]    others;
    logic [SEL_W:0]      pick_all;
    logic [SEL_W:0]      pick_oth;
    logic [DW-1:0]       mux_y;

    assign busy     = (state_q == GRANT);
    assign others   = req & ~gnt;
    assign pick_all = rr_pick(req, ptr);
    assign pick_oth = rr_pick(others, ptr);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        sel_d   = sel2;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_all[SEL_W]) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << pick_all[SEL_W-1:0];
                    sel_d   = pick_all[SEL_W-1:0];
                    ptr_d   = pick_all[SEL_W-1:0] + SEL_W'(1);
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!req[sel2] || hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                    // Owner released or used up its slot: hand over if anyone else waits.
                    if (pick_oth[SEL_W]) begin
                        gnt_d  = N_REQ'(1) << pick_oth[SEL_W-1:0];
                        sel_d  = pick_oth[SEL_W-1:0];
                        ptr_d  = pick_oth[SEL_W-1:0] + SEL_W'(1);
                        hold_d = '0;
                    end else if (!req[sel2]) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end else begin
                        // Sole owner at the limit keeps the bus; its slot restarts.
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    MUX4x1_4bit u_mux (
        .d0  (in0),
        .d1  (in1),
        .d2  (in2),
        .d3  (in3),
        .sel (sel2),
        .y   (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt      <= '0;
            sel2     <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            out      <= '0;
            out_vld  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt      <= gnt_d;
            sel2     <= sel_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
            out      <= busy ? mux_y : '0;
            out_vld  <= busy;
        end
    end

endmodule

// File: tb/tb_bus_arb_4x4.sv
// tb/tb_bus_arb_4x4.sv - directed scoreboard bench for bus_arb_4x4
module tb_bus_arb_4x4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] in0, in1, in2, in3;
    logic [3:0] gnt;
    logic [1:0] sel2;
    logic [3:0] out;
    logic       out_vld;
    logic       busy;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       vld;
        logic [3:0] out;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   vec_n;

    bus_arb_4x4 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .gnt     (gnt),
        .sel2    (sel2),
        .out     (out),
        .out_vld (out_vld),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, want);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                       input logic [1:0] es, input logic eb, input logic ev, input logic [3:0] eo);
        exp_t e;
        @(negedge clk);
        rst   = r;
        req   = rq;
        e.gnt = eg;
        e.sel = es;
        e.busy = eb;
        e.vld = ev;
        e.out = eo;
        e.idx = vec_n;
        vec_n++;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",     e.idx, {4'b0, gnt},     {4'b0, e.gnt});
                chk("sel2",    e.idx, {6'b0, sel2},    {6'b0, e.sel});
                chk("busy",    e.idx, {7'b0, busy},    {7'b0, e.busy});
                chk("out_vld", e.idx, {7'b0, out_vld}, {7'b0, e.vld});
                chk("out",     e.idx, {4'b0, out},     {4'b0, e.out});
            end
        end
    end

    initial begin : stim
        logic [3:0] dat [4];
        int         ord [5];
        logic [3:0] eo;
        total = 0;
        bad   = 0;
        vec_n = 0;
        rst = 1'b1;
        req = 4'b0000;
        in0 = 4'h1;
        in1 = 4'h6;
        in2 = 4'hA;
        in3 = 4'hC;
        dat[0] = 4'h1; dat[1] = 4'h6; dat[2] = 4'hA; dat[3] = 4'hC;
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
        repeat (2) @(posedge clk);

        // reset state, then single requester 2 and idle return
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'h0);
        cyc(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 4'hA);
        cyc(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 4'hA);
        cyc(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 4'h0);

        // all requesting from a fresh pointer: 0,1,2,3,0 each for 4 cycles, no gaps
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'h0);
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                if (g == 0 && c == 0) eo = 4'h0;
                else if (c == 0)      eo = dat[ord[g-1]];
                else                  eo = dat[ord[g]];
                cyc(1'b0, 4'b1111, 4'b0001 << ord[g], 2'(ord[g]), 1'b1,
                    !(g == 0 && c == 0), eo);
            end
        end

        // early release: owner 1 drops while 3 waits
        cyc(1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1, 4'h1);
        cyc(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, 4'h6);
        cyc(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 4'h6);
        cyc(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 4'hC);

        // sole owner 0 across several hold-limit boundaries
        cyc(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 4'hC);
        for (int i = 0; i < 12; i++)
            cyc(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 4'h1);

        // reset mid-grant of requester 1, then 1 wins first with ptr back at 0
        cyc(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 4'h1);
        cyc(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'h0);
        cyc(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, 4'h6);
        cyc(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1, 4'h6);
        cyc(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 4'h0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
